sd_to_bin_converter: RTL and testbench

SD_TO_BIN_CONVERTER -- requirements
Module: sd_to_bin_converter

---
 rtl/sd_conv_pkg.sv | 24 ++
 rtl/sd_to_bin_converter_if.sv | 40 ++++
 rtl/sd_otf_step.sv | 34 +++
 rtl/sd_to_bin_converter.sv | 114 +++++++++++
 tb/tb_sd_to_bin_converter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/sd_conv_pkg.sv
// Shared constants and types for the signed-digit to binary converter.
package sd_conv_pkg;

  localparam int SD_N_DEFAULT = 8;

  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;
  localparam logic [1:0] DIG_ZERO = 2'b00;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } sd_state_e;

  // 2'b11 has both halves set and is read as zero, so only exact codes count.
  function automatic logic dig_is_pos(input logic [1:0] d);
    return d == DIG_POS;
  endfunction

  function automatic logic dig_is_neg(input logic [1:0] d);
    return d == DIG_NEG;
  endfunction

endpackage

// File: rtl/sd_to_bin_converter_if.sv
// Digit-in / result-out handshake bundle. result_neg/result_zero exist only
// when SD_CONV_FLAGS_EN is defined.
interface sd_to_bin_converter_if
  import sd_conv_pkg::*;
#(
  parameter int N = SD_N_DEFAULT
) ();

  logic [1:0] digit_in;
  logic       digit_vld;
  logic       digit_rdy;
  logic [N:0] result;
  logic       result_vld;
  logic       result_rdy;
`ifdef SD_CONV_FLAGS_EN
  logic       result_neg;
  logic       result_zero;
`endif

`ifdef SD_CONV_FLAGS_EN
  modport slave (
    input  digit_in, digit_vld, result_rdy,
    output digit_rdy, result, result_vld, result_neg, result_zero
  );
  modport master (
    output digit_in, digit_vld, result_rdy,
    input  digit_rdy, result, result_vld, result_neg, result_zero
  );
`else
  modport slave (
    input  digit_in, digit_vld, result_rdy,
    output digit_rdy, result, result_vld
  );
  modport master (
    output digit_in, digit_vld, result_rdy,
    input  digit_rdy, result, result_vld
  );
`endif

endinterface

// File: rtl/sd_otf_step.sv
// One on-the-fly conversion step: next Q/QM for a single signed digit.
// Every branch is a shift with a constant LSB, so no adder is involved.
module sd_otf_step
  import sd_conv_pkg::*;
#(
  parameter int W = SD_N_DEFAULT + 1
) (
  input  logic [1:0]   digit,
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic pos;
  logic neg;

  assign pos = dig_is_pos(digit);
  assign neg = dig_is_neg(digit);

  always_comb begin
    q_next  = {q[W-2:0], pos};
    qm_next = {qm[W-2:0], 1'b1};
    if (neg) begin
      q_next = {qm[W-2:0], 1'b1};
    end
    if (pos) begin
      qm_next = {q[W-2:0], 1'b0};
    end else if (neg) begin
      qm_next = {qm[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_to_bin_converter.sv
// Serial radix-2 signed-digit to two's-complement converter, MSB first.
// Define SD_CONV_FLAGS_EN to add registered result_neg / result_zero flags.
module sd_to_bin_converter
  import sd_conv_pkg::*;
#(
  parameter int N = SD_N_DEFAULT
) (
  input  logic                  clk,
  input  logic                  asyn_reset_n,
  sd_to_bin_converter_if.slave  bus
);

  localparam int W  = N + 1;
  localparam int CW = (N > 2) ? $clog2(N) : 1;

  sd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  qm_q, qm_d;
  logic [W-1:0]  result_q, result_d;
  logic [W-1:0]  q_step, qm_step;
  logic          xfer;
  logic          last;
`ifdef SD_CONV_FLAGS_EN
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
`endif

  sd_otf_step #(.W(W)) u_step (
    .digit   (bus.digit_in),
    .q       (q_q),
    .qm      (qm_q),
    .q_next  (q_step),
    .qm_next (qm_step)
  );

  assign xfer = bus.digit_vld && (state_q == COLLECT);
  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    qm_d     = qm_q;
    result_d = result_q;
`ifdef SD_CONV_FLAGS_EN
    neg_d    = neg_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          q_d  = q_step;
          qm_d = qm_step;
          if (last) begin
            cnt_d    = '0;
            state_d  = HOLD;
            result_d = q_step;
`ifdef SD_CONV_FLAGS_EN
            neg_d    = q_step[W-1];
            zero_d   = (q_step == '0);
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // Q/QM are re-seeded here so the next word starts clean.
        if (bus.result_rdy) begin
          state_d = COLLECT;
          q_d     = '0;
          qm_d    = '1;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      q_q      <= '0;
      qm_q     <= '1;
      result_q <= '0;
`ifdef SD_CONV_FLAGS_EN
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      qm_q     <= qm_d;
      result_q <= result_d;
`ifdef SD_CONV_FLAGS_EN
      neg_q    <= neg_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign bus.digit_rdy  = (state_q == COLLECT);
  assign bus.result_vld = (state_q == HOLD);
  assign bus.result     = result_q;
`ifdef SD_CONV_FLAGS_EN
  assign bus.result_neg  = neg_q;
  assign bus.result_zero = zero_q;
`endif

endmodule

// File: tb/tb_sd_to_bin_converter.sv
// Self-checking bench: directed and random words against an arithmetic model.
module tb_sd_to_bin_converter;
  import sd_conv_pkg::*;

  localparam int N = 8;

  logic clk;
  logic asyn_reset_n;
  int   checks;
  int   errors;

  sd_to_bin_converter_if #(.N(N)) bus ();

  sd_to_bin_converter #(.N(N)) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value of one encoded digit as the model sees it.
  function automatic int dig_val(input logic [1:0] d);
    if (d == 2'b10) return 1;
    if (d == 2'b01) return -1;
    return 0;
  endfunction

  function automatic int word_val(input logic [2*N-1:0] digs);
    int v = 0;
    for (int i = N - 1; i >= 0; i--) v = 2 * v + dig_val(digs[2*i +: 2]);
    return v;
  endfunction

  task automatic send_digit(input logic [1:0] d);
    int t = 0;
    @(negedge clk);
    if ($urandom_range(0, 3) == 0) begin
      bus.digit_vld = 1'b0;
      bus.digit_in  = 2'($urandom);
      @(negedge clk);
    end
    bus.digit_in  = d;
    bus.digit_vld = 1'b1;
    while (!bus.digit_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rdy_timeout", 32'(t < 50), 32'd1);
    @(posedge clk);
    #1 bus.digit_vld = 1'b0;
  endtask

  task automatic run_word(input string name, input logic [2*N-1:0] digs,
                          input bit hold5, output logic [N:0] res);
    int          v;
    logic [N:0]  exp_res;
    v       = word_val(digs);
    exp_res = (N+1)'(v);
    for (int i = N - 1; i >= 0; i--) begin
      if (i == 0) begin
        @(negedge clk);
        check({name, "_vld_early"}, 32'(bus.result_vld), 32'd0);
      end
      send_digit(digs[2*i +: 2]);
    end
    @(negedge clk);
    res = bus.result;
    check({name, "_vld"}, 32'(bus.result_vld), 32'd1);
    check({name, "_result"}, 32'(bus.result), 32'(exp_res));
    check({name, "_rdy_hold"}, 32'(bus.digit_rdy), 32'd0);
`ifdef SD_CONV_FLAGS_EN
    check({name, "_neg"}, 32'(bus.result_neg), 32'(v < 0));
    check({name, "_zero"}, 32'(bus.result_zero), 32'(v == 0));
`endif
    if (hold5) begin
      bus.result_rdy = 1'b0;
      bus.digit_vld  = 1'b1;
      bus.digit_in   = 2'b10;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check({name, "_held_result"}, 32'(bus.result), 32'(exp_res));
        check({name, "_held_vld"}, 32'(bus.result_vld), 32'd1);
        check({name, "_held_rdy"}, 32'(bus.digit_rdy), 32'd0);
      end
    end
    bus.result_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.result_rdy = 1'b0;
    bus.digit_vld  = 1'b0;
    @(negedge clk);
    check({name, "_vld_drop"}, 32'(bus.result_vld), 32'd0);
    check({name, "_rdy_back"}, 32'(bus.digit_rdy), 32'd1);
    $display("word %s digits=%h model=%0d result=%h", name, digs, v, res);
  endtask

  initial begin
    logic [N:0]     res;
    logic [2*N-1:0] rw;
    checks         = 0;
    errors         = 0;
    asyn_reset_n   = 1'b0;
    bus.digit_in   = 2'b00;
    bus.digit_vld  = 1'b0;
    bus.result_rdy = 1'b0;
    #12;
    check("reset_vld", 32'(bus.result_vld), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_rdy", 32'(bus.digit_rdy), 32'd1);
`ifdef SD_CONV_FLAGS_EN
    check("reset_neg", 32'(bus.result_neg), 32'd0);
    check("reset_zero", 32'(bus.result_zero), 32'd0);
`endif
    @(negedge clk);
    asyn_reset_n = 1'b1;

    run_word("plus_then_zero", 16'h8000, 1'b0, res);
    check("plus_then_zero_lit", 32'(res), 32'h080);
    run_word("all_minus", 16'h5555, 1'b0, res);
    check("all_minus_lit", 32'(res), 32'h101);
    run_word("alternating", 16'h9999, 1'b0, res);
    check("alternating_lit", 32'(res), 32'h055);
    run_word("plus_minus_run", 16'h9555, 1'b0, res);
    check("plus_minus_run_lit", 32'(res), 32'h001);
    run_word("all_plus", 16'hAAAA, 1'b0, res);

    // Backpressured word followed by a word that must arrive intact.
    run_word("held", 16'($urandom), 1'b1, res);
    run_word("after_hold", 16'h8000, 1'b0, res);
    check("after_hold_lit", 32'(res), 32'h080);

    // Reset in the middle of a word discards the partial digits.
    send_digit(2'b10);
    send_digit(2'b10);
    send_digit(2'b01);
    @(negedge clk);
    asyn_reset_n = 1'b0;
    #1;
    check("midreset_vld", 32'(bus.result_vld), 32'd0);
    check("midreset_result", 32'(bus.result), 32'd0);
    check("midreset_rdy", 32'(bus.digit_rdy), 32'd1);
    @(negedge clk);
    asyn_reset_n = 1'b1;
    run_word("zeros_with_11", 16'h0C3C, 1'b0, res);
    check("zeros_with_11_lit", 32'(res), 32'h000);

    for (int k = 0; k < 24; k++) begin
      rw = 16'($urandom);
      run_word($sformatf("rand%0d", k), rw, ($urandom_range(0, 3) == 0), res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
